time_ascii_encoder: RTL and testbench

TIME_ASCII_ENCODER -- requirements
Module: time_ascii_encoder

---
 rtl/time_ascii_encoder_pkg.sv | 19 +
 rtl/bin2ascii2.sv | 22 ++
 rtl/time_ascii_encoder.sv | 115 +++++++++++
 tb/tb_time_ascii_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_ascii_encoder_pkg.sv
// Shared constants and FSM encoding for the time-of-day ASCII message encoder.
package time_ascii_encoder_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [3:0] LAST_IDX_CRLF   = 4'd12;
    localparam logic [3:0] LAST_IDX_NOCRLF = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitAck,
        StWaitDone
    } state_e;

endpackage

// File: rtl/bin2ascii2.sv
// Saturating 7-bit binary to two ASCII decimal digits, tens first; purely combinational.
module bin2ascii2
    import time_ascii_encoder_pkg::*;
(
    input  logic [6:0] i_bin,
    output logic [7:0] o_tens,
    output logic [7:0] o_ones
);

    logic [6:0] w_sat;
    logic [6:0] w_tens;
    logic [6:0] w_ones;

    always_comb begin
        w_sat  = (i_bin > 7'd99) ? 7'd99 : i_bin;
        w_tens = w_sat / 7'd10;
        w_ones = w_sat % 7'd10;
        o_tens = ASCII_ZERO + {1'b0, w_tens};
        o_ones = ASCII_ZERO + {1'b0, w_ones};
    end

endmodule

// File: rtl/time_ascii_encoder.sv
// Sends a snapshot of HH:MM:SS:CC (optionally CR LF) one byte at a time to a UART transmitter.
module time_ascii_encoder
    import time_ascii_encoder_pkg::*;
#(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h3A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [6:0] t_hour,
    input  logic [6:0] t_min,
    input  logic [6:0] t_sec,
    input  logic [6:0] t_cent,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       enc_busy
);

    localparam logic [3:0] LAST_IDX = SEND_CRLF ? LAST_IDX_CRLF : LAST_IDX_NOCRLF;

    state_e     r_state;
    logic [3:0] r_idx;
    logic [6:0] r_hour;
    logic [6:0] r_min;
    logic [6:0] r_sec;
    logic [6:0] r_cent;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_enc_busy;

    logic [7:0] w_hour_t, w_hour_o, w_min_t, w_min_o;
    logic [7:0] w_sec_t, w_sec_o, w_cent_t, w_cent_o;
    logic [7:0] w_byte;

    bin2ascii2 u_hour (.i_bin(r_hour), .o_tens(w_hour_t), .o_ones(w_hour_o));
    bin2ascii2 u_min  (.i_bin(r_min),  .o_tens(w_min_t),  .o_ones(w_min_o));
    bin2ascii2 u_sec  (.i_bin(r_sec),  .o_tens(w_sec_t),  .o_ones(w_sec_o));
    bin2ascii2 u_cent (.i_bin(r_cent), .o_tens(w_cent_t), .o_ones(w_cent_o));

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:                w_byte = w_hour_t;
            4'd1:                w_byte = w_hour_o;
            4'd3:                w_byte = w_min_t;
            4'd4:                w_byte = w_min_o;
            4'd6:                w_byte = w_sec_t;
            4'd7:                w_byte = w_sec_o;
            4'd9:                w_byte = w_cent_t;
            4'd10:               w_byte = w_cent_o;
            4'd2, 4'd5, 4'd8:    w_byte = SEP_CHAR;
            4'd11:               w_byte = ASCII_CR;
            4'd12:               w_byte = ASCII_LF;
            default:             w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_idx      <= 4'd0;
            r_hour     <= 7'd0;
            r_min      <= 7'd0;
            r_sec      <= 7'd0;
            r_cent     <= 7'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_enc_busy <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (send_req) begin
                        r_hour     <= t_hour;
                        r_min      <= t_min;
                        r_sec      <= t_sec;
                        r_cent     <= t_cent;
                        r_idx      <= 4'd0;
                        r_enc_busy <= 1'b1;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_byte;
                        r_state    <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (tx_busy) r_state <= StWaitDone;
                end
                StWaitDone: begin
                    if (!tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_enc_busy <= 1'b0;
                            r_state    <= StIdle;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= StStart;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign enc_busy = r_enc_busy;

endmodule

// File: tb/tb_time_ascii_encoder.sv
// Randomised self-checking bench: two encoders (with and without CR LF) against a UART busy model.
module tb_time_ascii_encoder;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_req = 1'b0;
    logic [6:0] t_hour = '0, t_min = '0, t_sec = '0, t_cent = '0;
    logic       tx_busy0, tx_busy1, tx_start0, tx_start1, enc_busy0, enc_busy1;
    logic [7:0] tx_data0, tx_data1;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  busy_len = 10;
    bit  hold_busy = 1'b0;
    int  cnt0, cnt1, viol0 = 0, viol1 = 0;
    logic prev0, prev1;
    bq_t q0, q1;

    always #5 clk = ~clk;

    time_ascii_encoder u_dut0 (
        .clk(clk), .rst(rst), .send_req(send_req),
        .t_hour(t_hour), .t_min(t_min), .t_sec(t_sec), .t_cent(t_cent),
        .tx_busy(tx_busy0), .tx_start(tx_start0), .tx_data(tx_data0), .enc_busy(enc_busy0)
    );

    time_ascii_encoder #(.SEND_CRLF(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .send_req(send_req),
        .t_hour(t_hour), .t_min(t_min), .t_sec(t_sec), .t_cent(t_cent),
        .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1), .enc_busy(enc_busy1)
    );

    // UART models: busy for busy_len cycles after each launched byte
    assign tx_busy0 = hold_busy | (cnt0 > 0);
    assign tx_busy1 = hold_busy | (cnt1 > 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 0;
            prev0 <= 1'b0;
        end else begin
            prev0 <= tx_start0;
            if (tx_start0) begin
                if (prev0 || tx_busy0) viol0 <= viol0 + 1;
                q0.push_back(tx_data0);
                cnt0 <= busy_len;
            end else if (cnt0 > 0) cnt0 <= cnt0 - 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= 0;
            prev1 <= 1'b0;
        end else begin
            prev1 <= tx_start1;
            if (tx_start1) begin
                if (prev1 || tx_busy1) viol1 <= viol1 + 1;
                q1.push_back(tx_data1);
                cnt1 <= busy_len;
            end else if (cnt1 > 0) cnt1 <= cnt1 - 1;
        end
    end

    function automatic bq_t ref_msg(input int h, input int m, input int s, input int c,
                                    input bit crlf);
        bq_t r;
        int  f[4];
        int  v;
        f = '{h, m, s, c};
        for (int i = 0; i < 4; i++) begin
            v = (f[i] > 99) ? 99 : f[i];
            r.push_back(8'(48 + v / 10));
            r.push_back(8'(48 + v % 10));
            if (i < 3) r.push_back(8'h3A);
        end
        if (crlf) begin
            r.push_back(8'h0D);
            r.push_back(8'h0A);
        end
        return r;
    endfunction

    task automatic pulse_send(input int h, input int m, input int s, input int c);
        @(negedge clk);
        t_hour = 7'(h); t_min = 7'(m); t_sec = 7'(s); t_cent = 7'(c);
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!enc_busy0 && !enc_busy1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks += 6;
        if (tx_start0 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start0 got %b want 0", tx_start0); end
        if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data0 got %h want 00", tx_data0); end
        if (enc_busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_enc_busy0 got %b want 0", enc_busy0); end
        if (tx_start1 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start1 got %b want 0", tx_start1); end
        if (tx_data1 !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data1 got %h want 00", tx_data1); end
        if (enc_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_enc_busy1 got %b want 0", enc_busy1); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        bq_t e0, e1;
        int  b0, b1;
        bit  ok;
        busy_len = 10;
        b0 = q0.size(); b1 = q1.size();
        e0 = ref_msg(12, 34, 56, 78, 1'b1);
        e1 = ref_msg(12, 34, 56, 78, 1'b0);
        @(negedge clk);
        t_hour = 7'd12; t_min = 7'd34; t_sec = 7'd56; t_cent = 7'd78;
        send_req = 1'b1;
        @(posedge clk); #1;
        n_checks += 2;
        if (enc_busy0 !== 1'b1) begin n_fail++; $display("FAIL accept_enc_busy got %b want 1", enc_busy0); end
        if (tx_start0 !== 1'b0) begin n_fail++; $display("FAIL accept_no_start got %b want 0", tx_start0); end
        @(negedge clk);
        send_req = 1'b0;
        @(posedge clk); #1;
        n_checks += 2;
        if (tx_start0 !== 1'b1) begin n_fail++; $display("FAIL latency_start got %b want 1", tx_start0); end
        if (tx_data0 !== 8'h31) begin n_fail++; $display("FAIL latency_data got %h want 31", tx_data0); end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout got busy want idle"); end
        n_checks += 2;
        if (q0.size() - b0 != e0.size()) begin
            n_fail++; $display("FAIL basic_len0 got %0d want %0d", q0.size() - b0, e0.size());
        end
        if (q1.size() - b1 != e1.size()) begin
            n_fail++; $display("FAIL basic_len1 got %0d want %0d", q1.size() - b1, e1.size());
        end
        for (int i = 0; i < e0.size() && b0 + i < q0.size(); i++) begin
            n_checks++;
            if (q0[b0+i] !== e0[i]) begin
                n_fail++; $display("FAIL basic_byte0[%0d] got %h want %h", i, q0[b0+i], e0[i]);
            end
        end
        for (int i = 0; i < e1.size() && b1 + i < q1.size(); i++) begin
            n_checks++;
            if (q1[b1+i] !== e1[i]) begin
                n_fail++; $display("FAIL basic_byte1[%0d] got %h want %h", i, q1[b1+i], e1[i]);
            end
        end
    endtask

    task automatic test_messages(input int n, input bit force_sat);
        bq_t e0, e1;
        int  b0, b1, h, m, s, c;
        bit  ok;
        for (int k = 0; k < n; k++) begin
            busy_len = $urandom_range(1, 6);
            h = $urandom_range(0, 127); m = $urandom_range(0, 127);
            s = $urandom_range(0, 127); c = $urandom_range(0, 127);
            if (force_sat) begin h = 99; c = 120; end
            if (n == 1 && !force_sat) begin h = 0; m = 5; s = 9; c = 3; end
            e0 = ref_msg(h, m, s, c, 1'b1);
            e1 = ref_msg(h, m, s, c, 1'b0);
            b0 = q0.size(); b1 = q1.size();
            pulse_send(h, m, s, c);
            wait_idle(ok);
            n_checks += 3;
            if (!ok) begin n_fail++; $display("FAIL msg_timeout[%0d] got busy want idle", k); end
            if (q0.size() - b0 != e0.size()) begin
                n_fail++; $display("FAIL msg_len0[%0d] got %0d want %0d", k, q0.size() - b0, e0.size());
            end
            if (q1.size() - b1 != e1.size()) begin
                n_fail++; $display("FAIL msg_len1[%0d] got %0d want %0d", k, q1.size() - b1, e1.size());
            end
            for (int i = 0; i < e0.size() && b0 + i < q0.size(); i++) begin
                n_checks++;
                if (q0[b0+i] !== e0[i]) begin
                    n_fail++; $display("FAIL msg_byte0[%0d][%0d] got %h want %h", k, i, q0[b0+i], e0[i]);
                end
            end
            for (int i = 0; i < e1.size() && b1 + i < q1.size(); i++) begin
                n_checks++;
                if (q1[b1+i] !== e1[i]) begin
                    n_fail++; $display("FAIL msg_byte1[%0d][%0d] got %h want %h", k, i, q1[b1+i], e1[i]);
                end
            end
        end
    endtask

    task automatic test_drop;
        bq_t e0;
        int  b0, h, m, s, c, tgt;
        bit  ok, hit;
        busy_len = 4;
        h = $urandom_range(0, 99); m = $urandom_range(0, 99);
        s = $urandom_range(0, 99); c = $urandom_range(0, 99);
        e0 = ref_msg(h, m, s, c, 1'b1);
        b0 = q0.size();
        pulse_send(h, m, s, c);
        for (int p = 0; p < 3; p++) begin
            tgt = b0 + 3 + 2 * p;
            for (int i = 0; i < 200 && q0.size() < tgt; i++) @(negedge clk);
            t_hour = 7'($urandom_range(0, 127)); t_min = 7'($urandom_range(0, 127));
            t_sec = 7'($urandom_range(0, 127)); t_cent = 7'($urandom_range(0, 127));
            send_req = 1'b1;
            @(negedge clk);
            send_req = 1'b0;
        end
        // Request in the very cycle the encoder returns to idle must be dropped
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (q0.size() - b0 == e0.size() && !tx_busy0) hit = 1'b1;
        end
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        wait_idle(ok);
        repeat (30) @(negedge clk);
        n_checks += 4;
        if (!hit) begin n_fail++; $display("FAIL drop_reach_end got timeout want last byte"); end
        if (!ok) begin n_fail++; $display("FAIL drop_timeout got busy want idle"); end
        if (q0.size() - b0 != e0.size()) begin
            n_fail++; $display("FAIL drop_len got %0d want %0d", q0.size() - b0, e0.size());
        end
        if (enc_busy0 !== 1'b0) begin n_fail++; $display("FAIL drop_idle got %b want 0", enc_busy0); end
        for (int i = 0; i < e0.size() && b0 + i < q0.size(); i++) begin
            n_checks++;
            if (q0[b0+i] !== e0[i]) begin
                n_fail++; $display("FAIL drop_byte[%0d] got %h want %h", i, q0[b0+i], e0[i]);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_busy_hold;
        bq_t e0;
        int  b0, b1;
        bit  ok;
        busy_len = 2;
        e0 = ref_msg(7, 8, 9, 10, 1'b1);
        b0 = q0.size(); b1 = q1.size();
        hold_busy = 1'b1;
        pulse_send(7, 8, 9, 10);
        repeat (20) @(negedge clk);
        n_checks += 3;
        if (q0.size() != b0) begin n_fail++; $display("FAIL hold_no_start0 got %0d want 0", q0.size() - b0); end
        if (q1.size() != b1) begin n_fail++; $display("FAIL hold_no_start1 got %0d want 0", q1.size() - b1); end
        if (enc_busy0 !== 1'b1) begin n_fail++; $display("FAIL hold_enc_busy got %b want 1", enc_busy0); end
        hold_busy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (q0.size() != b0 + 1 || q0[b0] !== 8'h30) begin
            n_fail++; $display("FAIL hold_first_byte got %0d bytes want 1 byte 30", q0.size() - b0);
        end
        wait_idle(ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL hold_timeout got busy want idle"); end
        if (q0.size() - b0 != e0.size()) begin
            n_fail++; $display("FAIL hold_len got %0d want %0d", q0.size() - b0, e0.size());
        end
        for (int i = 0; i < e0.size() && b0 + i < q0.size(); i++) begin
            n_checks++;
            if (q0[b0+i] !== e0[i]) begin
                n_fail++; $display("FAIL hold_byte[%0d] got %h want %h", i, q0[b0+i], e0[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int  b0, s0, s1;
        bit  ok;
        busy_len = 3;
        b0 = q0.size();
        pulse_send(21, 43, 5, 67);
        for (int i = 0; i < 300 && q0.size() < b0 + 5; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        s0 = q0.size(); s1 = q1.size();
        n_checks += 4;
        if (s0 != b0 + 5) begin n_fail++; $display("FAIL rmid_progress got %0d want 5", s0 - b0); end
        if (tx_start0 !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_start got %b want 0", tx_start0); end
        if (tx_data0 !== 8'h00) begin n_fail++; $display("FAIL rmid_tx_data got %h want 00", tx_data0); end
        if (enc_busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_enc_busy got %b want 0", enc_busy0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        n_checks += 3;
        if (q0.size() != s0) begin n_fail++; $display("FAIL rmid_quiet0 got %0d want 0", q0.size() - s0); end
        if (q1.size() != s1) begin n_fail++; $display("FAIL rmid_quiet1 got %0d want 0", q1.size() - s1); end
        if (enc_busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %b want 0", enc_busy0); end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_messages(1, 1'b0);
        test_messages(1, 1'b1);
        test_messages(6, 1'b0);
        test_drop();
        test_busy_hold();
        test_reset_mid();
        test_messages(2, 1'b0);
        n_checks += 2;
        if (viol0 != 0) begin n_fail++; $display("FAIL start_rule0 got %0d want 0", viol0); end
        if (viol1 != 0) begin n_fail++; $display("FAIL start_rule1 got %0d want 0", viol1); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
